// File: rtl/clk_div_bank.sv
// Bank of NCH runtime-programmable clock dividers sharing one source clock.
// Each channel gives a 50%-duty divided clock (even or odd ratio) and a period-start tick.
module clk_div_bank #(
   parameter int NCH     = 4,
   parameter int DW      = 8,
   parameter int DEF_DIV = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    en,
   input  logic [NCH*DW-1:0] cfg_div,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              sync,
   output logic [NCH-1:0]    clk_out,
   output logic [NCH-1:0]    tick
);

   // Ratios below 2 cannot produce a clock, so they are clamped to 2.
   function automatic logic [DW-1:0] fix_ratio(input logic [DW-1:0] r);
      return (r < DW'(2)) ? DW'(2) : r;
   endfunction

   // High-phase length ceil(n/2); one extra bit so the maximum ratio cannot overflow.
   function automatic logic [DW:0] half_up(input logic [DW-1:0] n);
      logic [DW:0] t;
      t = {1'b0, n} + {{DW{1'b0}}, 1'b1};
      return t >> 1;
   endfunction

   logic [NCH-1:0] pend;
   logic           xfer;

   assign cfg_ready = ~|pend;
   assign xfer      = cfg_valid & cfg_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic          run;
      logic [DW-1:0] cnt;
      logic [DW-1:0] n_act;
      logic [DW-1:0] p_rat;
      logic          pend_r;
      logic          pos;
      logic          neg;
      logic          tk;
      logic [DW-1:0] fld;
      logic [DW-1:0] p_eff;
      logic          pend_eff;
      logic [DW-1:0] cnt_inc;
      logic [DW:0]   h;
      logic          wrap;

      assign fld      = fix_ratio(cfg_div[i*DW +: DW]);
      assign pend_eff = xfer | pend_r;
      assign p_eff    = xfer ? fld : p_rat;
      assign cnt_inc  = cnt + DW'(1);
      assign h        = half_up(n_act);
      assign wrap     = (cnt == n_act - DW'(1));

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            run    <= 1'b0;
            cnt    <= '0;
            n_act  <= DW'(DEF_DIV);
            p_rat  <= DW'(DEF_DIV);
            pend_r <= 1'b0;
            pos    <= 1'b0;
            tk     <= 1'b0;
         end else begin
            if (xfer)
               p_rat <= fld;
            if (!run) begin
               // Idle channels take a new ratio immediately; there is no period to protect.
               cnt    <= '0;
               pend_r <= 1'b0;
               if (pend_eff)
                  n_act <= p_eff;
               run <= en[i];
               pos <= en[i];
               tk  <= en[i];
            end else if (sync) begin
               cnt    <= '0;
               pos    <= 1'b1;
               tk     <= 1'b1;
               pend_r <= 1'b0;
               if (pend_eff)
                  n_act <= p_eff;
            end else if (wrap) begin
               // Period boundary: the only point where ratio changes or a stop may land.
               cnt    <= '0;
               pend_r <= 1'b0;
               if (pend_eff)
                  n_act <= p_eff;
               run <= en[i];
               pos <= en[i];
               tk  <= en[i];
            end else begin
               cnt <= cnt_inc;
               pos <= ({1'b0, cnt_inc} < h);
               tk  <= 1'b0;
               if (xfer)
                  pend_r <= 1'b1;
            end
         end
      end

      // Half-cycle delayed copy of pos trims the odd-ratio high phase to N/2.
      always_ff @(negedge clk or negedge rst) begin
         if (!rst)
            neg <= 1'b0;
         else
            neg <= pos;
      end

      assign pend[i]    = pend_r;
      assign clk_out[i] = n_act[0] ? (pos & neg) : pos;
      assign tick[i]    = tk;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent programmable clock dividers on one source clock. Each channel has a runtime divide ratio (2..2^DW-1) and 50% duty for even and odd ratios. Ratio changes are glitch-free, and channels can be phase-aligned. A one-cycle period-start tick per channel is provided. The block sits beside the fixed-ratio divider blocks and supplies derived strobes and clocks to downstream logic.

## Interface
- NCH, 4: number of divider channels (1..16)
- DW, 8: ratio width per channel
- DEF_DIV, 2: ratio loaded into every channel at reset (must be ≥2)

- clk  in  1  source clock; all flops rising edge except odd-duty negedge stage
- rst  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel run enable
- cfg_div  in  NCH*DW  requested ratios, channel i at [i*DW +: DW]
- cfg_valid  in  1  ratio update request
- cfg_ready  out  1  bank can accept an update
- sync  in  1  one-cycle pulse; realigns all running channels
- clk_out  out  NCH  divided clocks
- tick  out  NCH  one-cycle pulse at each period start

## Operation
- Per-channel state:
  - run flag
  - cnt[DW-1:0]
  - active ratio N[DW-1:0]
  - pending ratio P and pending flag
  - pos register
  - neg register, clocked on the falling edge
- Let H = ceil(N/2).
- Start: at an edge where en[i]=1 and run=0:
  - run←1, cnt←0, pos←1, tick←1
  - N←P if pending, and pending clears
- Running: at each edge:
  - cnt←(cnt==N-1)?0:cnt+1
  - pos←(cnt_next<H)
  - tick←(cnt_next==0)
- Wrap boundary (cnt==N-1 at the edge):
  - If pending: N←P and pending clears. The new ratio governs the cycle starting at cnt=0.
  - If en[i]=0: run←0, cnt←0, pos←0, tick←0.
  - Disable therefore always completes the current period and never truncates a high phase.
- Output:
  - even N: clk_out[i] = pos
  - odd N: clk_out[i] = pos & neg, where neg samples pos on the falling edge of clk. High time is N/2 source cycles, low time N/2.
  - Parity is taken from the active N.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at a rising edge.
  - On transfer, each channel i latches P←cfg_div[i] and sets pending.
  - Idle channels (run=0) apply N←P at that same edge and clear pending.
  - cfg_ready = no channel pending.
  - cfg_ready drops the cycle after a transfer that leaves any running channel pending. It rises the cycle after the last pending channel applies.
- Illegal ratio: a cfg_div field of 0 or 1 is stored as 2.
- sync:
  - At an edge with sync=1, every running channel takes cnt←0, pos←1, tick←1, and a pending ratio applies.
  - Idle channels ignore sync.
  - sync may shorten one low phase to a minimum of 1 cycle. It never produces a high pulse shorter than the current H.
- Simultaneous events:
  - sync overrides the wrap and disable for that edge. A channel with en=0 stops at its next wrap.
  - cfg transfer and a wrap on the same edge: the newly latched P applies at that edge.
- Width: cnt compares are unsigned DW-bit. The maximum ratio 2^DW-1 wraps without overflow.

## Timing
- Reset (rst=0, asynchronous):
  - clk_out=0, tick=0, cfg_ready=1
  - all run=0, cnt=0, pos=0, neg=0, pending=0, N=DEF_DIV
- Release of rst is synchronised externally. The first active edge is the first rising clk with rst=1.
- Latency:
  - en sampled high at edge k gives clk_out rising at edge k for even N, and at the falling edge after k for odd N.
  - tick is high for cycle k..k+1.
- Period: exactly N clk cycles between consecutive rising edges of clk_out and between consecutive ticks.
- Reset mid-operation: outputs drop immediately (asynchronous). The glitch on reset assertion is accepted.

## Test plan
- Even ratio: reset, cfg_div ch0=4, ch1=6, en=2'b11.
  - ch0 gives 2 high / 2 low; ch1 gives 3 high / 3 low.
  - tick every 4 and every 6 cycles respectively; cfg_ready stays 1.
- Odd ratio: ch0=5 → clk_out high 2.5 cycles and low 2.5 cycles. The rising edge is on a falling clk edge; the period is 5 cycles.
- Glitch-free update: ch0 running at 8, request 3 at cnt=2.
  - cfg_ready=0 until wrap.
  - The 8-cycle period completes intact, then the period becomes 3; cfg_ready=1 the cycle after.
- Disable mid-high: ch0 at 6, drop en at cnt=1.
  - clk_out finishes 3 high / 3 low, then holds 0; tick stops; re-enable restarts at cnt=0.
- sync alignment: ch0=4, ch1=6 running out of phase, pulse sync.
  - Both ticks fire the next cycle; both clk_out rise together.
  - Ratio field 1 requested → behaves as 2.
- Async reset while running: rst low mid-cycle → all clk_out/tick 0 without a clock edge, cfg_ready=1, N=DEF_DIV after release.
